// File: rtl/bnn_input_loader.sv
// Binarizing pixel-stream loader: packs thresholded pixels into an INPUT_SIZE-bit activation frame.
// Define BNN_LOADER_DBUF_EN to add a separate output register so filling overlaps with frame hold.
module bnn_input_loader #(
   parameter int unsigned      INPUT_SIZE = 784,
   parameter int unsigned      PIX_W      = 8,
   parameter logic [PIX_W-1:0] THRESHOLD  = PIX_W'(128)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pix_valid,
   input  logic [PIX_W-1:0]      pix_data,
   input  logic                  pix_last,
   output logic                  pix_ready,
   output logic                  frame_valid,
   input  logic                  frame_ready,
   output logic [INPUT_SIZE-1:0] activations_out,
   output logic                  frame_err
);

   localparam int unsigned      CNT_W    = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(INPUT_SIZE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   typedef enum logic [0:0] {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t                state_r;
   state_t                next_state_s;
   logic [CNT_W-1:0]      cnt_r;
   logic [INPUT_SIZE-1:0] fill_buf_r;
   logic [INPUT_SIZE-1:0] fill_next_s;
   logic                  frame_valid_r;
   logic                  frame_err_r;
   logic                  pix_ready_r;
   logic                  accept_s;
   logic                  pix_bit_s;
   logic                  at_last_s;
   logic                  complete_s;
   logic                  frame_error_s;
   logic                  handshake_s;
   logic                  out_free_s;
   logic                  load_out_s;
`ifdef BNN_LOADER_DBUF_EN
   logic [INPUT_SIZE-1:0] out_r;
   logic [INPUT_SIZE-1:0] out_next_s;
`endif

   // Per-pixel handshake and framing decode; pixels are only taken while filling.
   always_comb begin
      accept_s      = pix_valid & pix_ready_r & (state_r == FILL);
      pix_bit_s     = (pix_data >= THRESHOLD);
      at_last_s     = (cnt_r == LAST_IDX);
      complete_s    = accept_s & pix_last & at_last_s;
      frame_error_s = accept_s & (pix_last ^ at_last_s);
      handshake_s   = frame_valid_r & frame_ready;
      out_free_s    = ~frame_valid_r | frame_ready;
   end

   // Fill buffer with the current pixel's bit merged in at the counter position.
   always_comb begin
      fill_next_s        = fill_buf_r;
      fill_next_s[cnt_r] = pix_bit_s;
   end

   // FSM next-state and output-load decision.
   always_comb begin
      next_state_s = state_r;
      load_out_s   = 1'b0;
`ifdef BNN_LOADER_DBUF_EN
      out_next_s   = out_r;
`endif
      case (state_r)
         FILL: begin
            if (complete_s) begin
`ifdef BNN_LOADER_DBUF_EN
               if (out_free_s) begin
                  load_out_s   = 1'b1;
                  out_next_s   = fill_next_s;
                  next_state_s = FILL;
               end else begin
                  next_state_s = HOLD;
               end
`else
               load_out_s   = 1'b1;
               next_state_s = HOLD;
`endif
            end else begin
               next_state_s = FILL;
            end
         end
         HOLD: begin
`ifdef BNN_LOADER_DBUF_EN
            // Completed frame parked in the fill buffer moves out once the output register frees.
            if (out_free_s) begin
               load_out_s   = 1'b1;
               out_next_s   = fill_buf_r;
               next_state_s = FILL;
            end else begin
               next_state_s = HOLD;
            end
`else
            if (handshake_s) begin
               next_state_s = FILL;
            end else begin
               next_state_s = HOLD;
            end
`endif
         end
         default: begin
            next_state_s = FILL;
         end
      endcase
   end

   // FSM state register; pix_ready is registered from the next state so it is low in reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= FILL;
         pix_ready_r <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         pix_ready_r <= (next_state_s == FILL);
      end
   end

   // Pixel counter and fill buffer; a framing error throws away the partial frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r      <= CNT_ZERO;
         fill_buf_r <= '0;
      end else if (frame_error_s) begin
         cnt_r      <= CNT_ZERO;
         fill_buf_r <= '0;
      end else if (accept_s) begin
         fill_buf_r <= fill_next_s;
         cnt_r      <= at_last_s ? CNT_ZERO : (cnt_r + CNT_ONE);
      end
   end

   // Frame handshake flags and error pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_valid_r <= 1'b0;
         frame_err_r   <= 1'b0;
      end else begin
         frame_err_r <= frame_error_s;
         if (load_out_s) begin
            frame_valid_r <= 1'b1;
         end else if (handshake_s) begin
            frame_valid_r <= 1'b0;
         end
      end
   end

`ifdef BNN_LOADER_DBUF_EN
   // Output register, written only on a frame transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_r <= '0;
      end else if (load_out_s) begin
         out_r <= out_next_s;
      end
   end

   assign activations_out = out_r;
`else
   assign activations_out = fill_buf_r;
`endif

   assign pix_ready   = pix_ready_r;
   assign frame_valid = frame_valid_r;
   assign frame_err   = frame_err_r;

endmodule

// File: doc/bnn_input_loader.md
BNN_INPUT_LOADER -- requirements
Module: bnn_input_loader

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 784: pixels per frame and width of the activation vector.
REQ-002 SHALL have parameter PIX_W, default 8: pixel width in bits.
REQ-003 SHALL have parameter THRESHOLD, default 128: binarization threshold, unsigned, PIX_W bits.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pix_valid  input  1  upstream pixel valid.
REQ-007 SHALL have port pix_data  input  PIX_W  unsigned pixel value.
REQ-008 SHALL have port pix_last  input  1  marks the final pixel of a frame.
REQ-009 SHALL have port pix_ready  output  1  loader can accept a pixel.
REQ-010 SHALL have port frame_valid  output  1  activations_out holds a complete frame.
REQ-011 SHALL have port frame_ready  input  1  network consumer accepts the frame.
REQ-012 SHALL have port activations_out  output  INPUT_SIZE  binarized frame; bit k is pixel k.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse on a framing error.

Function
REQ-014 A pixel SHALL be accepted only in a cycle where pix_valid and pix_ready are both 1.
REQ-015 An accepted pixel SHALL be binarized: bit = 1 if pix_data >= THRESHOLD, else 0 (unsigned compare).
REQ-016 Pixel index counter SHALL run 0..INPUT_SIZE-1 and SHALL write the bit at fill-buffer index equal to the counter.
REQ-017 The FSM SHALL have states FILL and HOLD; reset enters FILL with counter 0.
REQ-018 FILL: pixel accepted with counter = INPUT_SIZE-1 and pix_last = 1 -> frame complete; counter returns to 0.
REQ-019 Completion with last pixel accepted in cycle t SHALL produce frame_valid = 1 from cycle t+1, with activations_out equal to the full frame including that pixel.
REQ-020 Framing error SHALL apply when pix_last = 1 with counter < INPUT_SIZE-1, or pix_last = 0 with counter = INPUT_SIZE-1: frame_err pulses at t+1, partial frame discarded, counter returns to 0, FSM stays in FILL, frame_valid unchanged.
REQ-021 HOLD: frame_valid = 1; activations_out SHALL stay stable until frame_ready = 1 is sampled.
REQ-022 The frame handshake SHALL complete when frame_valid and frame_ready are both 1; frame_valid SHALL drop next cycle unless a new frame is transferred in that same cycle (REQ-029).
REQ-023 frame_ready while frame_valid = 0 SHALL be ignored.
REQ-024 pix_data, pix_last and activations_out content SHALL be don't-care or unchanged when the respective valid is low; no X SHALL propagate to frame_valid, pix_ready or frame_err.

Reset
REQ-025 Reset (rst = 0) SHALL asynchronously clear: frame_valid = 0, frame_err = 0, counter = 0, FSM = FILL, activations_out = all zero, fill buffer = zero.
REQ-026 pix_ready SHALL be 0 while rst = 0 and SHALL be 1 in the first cycle after release; reset mid-frame SHALL discard all partial and held data.

Configuration
REQ-027 Macro BNN_LOADER_DBUF_EN SHALL select double buffering.
REQ-028 Without BNN_LOADER_DBUF_EN: single buffer; pix_ready = 1 in FILL and 0 in HOLD; the FSM returns HOLD -> FILL on frame handshake; a pixel can be accepted the cycle after the handshake.
REQ-029 With BNN_LOADER_DBUF_EN: separate fill buffer and output register. A completed frame SHALL transfer to the output register when it is empty or is being handshaken in the same cycle. Otherwise the completed frame SHALL wait in the fill buffer with pix_ready = 0 until the output register frees; the transfer takes one cycle. pix_ready SHALL stay 1 while the fill buffer is not holding a completed frame.

Verification
REQ-030 Stream 784 pixels with values = index mod 256, pix_last on index 783, frame_ready = 1 -> frame_valid rises 1 cycle after the last accept; bit k = 1 exactly when (k mod 256) >= 128.
REQ-031 Stream a frame, hold frame_ready = 0 for 50 cycles -> activations_out stable and frame_valid = 1 throughout; without DBUF pix_ready = 0 throughout.
REQ-032 pix_last on pixel 99 -> frame_err pulses for exactly 1 cycle, no frame_valid; the next correct 784-pixel frame is delivered intact.
REQ-033 Drop rst to 0 after pixel 400 -> outputs zeroed immediately; a fresh 784-pixel frame after release is delivered with no residue from the aborted frame.
REQ-034 DBUF only: send two back-to-back frames with frame_ready = 0, then assert frame_ready -> first frame handed off, second frame appears on the next cycle, pix_ready = 0 only between completion of the second frame and its transfer.
REQ-035 Pixel values 127, 128, 255 and 0 -> bits 0, 1, 1, 0.
